// File: rtl/mini_cpu_pkg.sv
// rtl/mini_cpu_pkg.sv - opcodes, FSM encoding and instruction-field helpers for mini_cpu_core
package mini_cpu_pkg;

  localparam logic [2:0] OP_LOAD    = 3'd0;
  localparam logic [2:0] OP_ADD     = 3'd1;
  localparam logic [2:0] OP_ADDI    = 3'd2;
  localparam logic [2:0] OP_SUB     = 3'd3;
  localparam logic [2:0] OP_SUBI    = 3'd4;
  localparam logic [2:0] OP_MUL     = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd6;
  localparam logic [2:0] OP_DISPLAY = 3'd7;

  localparam logic [3:0] ST_OFF        = 4'd0;
  localparam logic [3:0] ST_WAIT_BOOT  = 4'd1;
  localparam logic [3:0] ST_SPLASH     = 4'd2;
  localparam logic [3:0] ST_IDLE       = 4'd3;
  localparam logic [3:0] ST_EXECUTE    = 4'd4;
  localparam logic [3:0] ST_LATCH      = 4'd5;
  localparam logic [3:0] ST_UPDATE_LCD = 4'd6;
  localparam logic [3:0] ST_WAIT_LCD   = 4'd7;
  localparam logic [3:0] ST_SHUTDOWN   = 4'd8;

  // Helpers work on a 64-bit view of the word so they stay independent of the core parameters.
  function automatic logic [63:0] low_mask(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic logic [2:0] field_op(input logic [63:0] w, input int ra_w, input int imm_w);
    return 3'((w >> (2 * ra_w + imm_w)) & 64'd7);
  endfunction

  function automatic logic [63:0] field_rd(input logic [63:0] w, input int ra_w, input int imm_w);
    return (w >> (ra_w + imm_w)) & low_mask(ra_w);
  endfunction

  function automatic logic [63:0] field_rs1(input logic [63:0] w, input int ra_w, input int imm_w);
    return (w >> imm_w) & low_mask(ra_w);
  endfunction

  function automatic logic [63:0] field_rs2(input logic [63:0] w, input int ra_w, input int imm_w);
    return (w >> (imm_w - ra_w)) & low_mask(ra_w);
  endfunction

  function automatic logic [63:0] field_imm(input logic [63:0] w, input int imm_w);
    return w & low_mask(imm_w);
  endfunction

  // Sign-magnitude to two's complement; -0 naturally folds to 0.
  function automatic logic [63:0] sm_decode(input logic [63:0] imm, input int imm_w);
    logic [63:0] mag;
    mag = imm & low_mask(imm_w - 1);
    return imm[imm_w-1] ? (64'd0 - mag) : mag;
  endfunction

endpackage

// File: rtl/mini_cpu_regfile.sv
// rtl/mini_cpu_regfile.sv - register file with two combinational reads, one write, synchronous clear-all
module mini_cpu_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  localparam int RA_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [RA_W-1:0]   raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/mini_cpu_core.sv
// rtl/mini_cpu_core.sv - switch-driven mini CPU: executes one snapshotted instruction per send release
module mini_cpu_core
  import mini_cpu_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int NUM_REGS     = 16,
  parameter int IMM_W        = 7,
  parameter int SAT_MODE     = 0,
  parameter int BOOT_WAIT    = 1000,
  parameter int LCD_MIN_WAIT = 15,
  localparam int RA_W        = $clog2(NUM_REGS),
  localparam int SW_W        = 3 + 2 * RA_W + IMM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button_power,
  input  logic              button_send,
  input  logic [SW_W-1:0]   switches,
  output logic              system_reset_out,
  output logic              show_splash_req,
  output logic              force_blank_req,
  output logic              lcd_start,
  output logic [2:0]        lcd_opcode,
  output logic [RA_W-1:0]   lcd_reg_index,
  output logic [DATA_W-1:0] lcd_value,
  input  logic              lcd_busy,
  output logic              cpu_ready,
  output logic              overflow_flag
);

  localparam logic signed [2*DATA_W-1:0] MAX_V = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] MIN_V = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [3:0]        state;
  logic [31:0]       cnt;
  logic              power_d, send_d, power_rel, send_rel;
  logic [SW_W-1:0]   instr;
  logic [2:0]        op;
  logic [RA_W-1:0]   rd, rs1, rs2, raddr_b;
  logic [DATA_W-1:0] imm_val, rdata_a, rdata_b, result;
  logic signed [2*DATA_W-1:0] a_x, b_x, i_x, exact;
  logic              ovf, rf_we, rf_clear;

  assign power_rel = power_d & ~button_power;
  assign send_rel  = send_d & ~button_send;
  assign cpu_ready = (state == ST_IDLE);

  always_comb begin
    op      = field_op(64'(instr), RA_W, IMM_W);
    rd      = RA_W'(field_rd(64'(instr), RA_W, IMM_W));
    rs1     = RA_W'(field_rs1(64'(instr), RA_W, IMM_W));
    rs2     = RA_W'(field_rs2(64'(instr), RA_W, IMM_W));
    imm_val = DATA_W'(sm_decode(field_imm(64'(instr), IMM_W), IMM_W));
    raddr_b = (op == OP_DISPLAY) ? rd : rs2;
  end

  always_comb begin
    a_x = {{DATA_W{rdata_a[DATA_W-1]}}, rdata_a};
    b_x = {{DATA_W{rdata_b[DATA_W-1]}}, rdata_b};
    i_x = {{DATA_W{imm_val[DATA_W-1]}}, imm_val};
    exact = '0;
    case (op)
      OP_LOAD: exact = i_x;
      OP_ADD:  exact = a_x + b_x;
      OP_ADDI: exact = a_x + i_x;
      OP_SUB:  exact = a_x - b_x;
      OP_SUBI: exact = a_x - i_x;
      OP_MUL:  exact = a_x * i_x;
      default: exact = '0;
    endcase
    ovf = (exact > MAX_V) || (exact < MIN_V);
    if (SAT_MODE != 0 && ovf)
      result = exact[2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      result = exact[DATA_W-1:0];
  end

  assign rf_we    = (state == ST_LATCH) && (op < OP_CLEAR);
  assign rf_clear = rst || (state == ST_OFF) || ((state == ST_LATCH) && (op == OP_CLEAR));

  mini_cpu_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk     (clk),
    .clear   (rf_clear),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (result),
    .raddr_a (rs1),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_OFF;
      cnt              <= '0;
      power_d          <= 1'b0;
      send_d           <= 1'b0;
      instr            <= '0;
      system_reset_out <= 1'b1;
      show_splash_req  <= 1'b0;
      force_blank_req  <= 1'b0;
      lcd_start        <= 1'b0;
      lcd_opcode       <= '0;
      lcd_reg_index    <= '0;
      lcd_value        <= '0;
      overflow_flag    <= 1'b0;
    end else begin
      power_d   <= button_power;
      send_d    <= button_send;
      lcd_start <= (state == ST_UPDATE_LCD);
      if (cnt != '1) cnt <= cnt + 32'd1;
      case (state)
        ST_OFF: begin
          system_reset_out <= 1'b1;
          if (power_rel) begin
            system_reset_out <= 1'b0;
            cnt              <= '0;
            state            <= ST_WAIT_BOOT;
          end
        end
        ST_WAIT_BOOT:
          if ((cnt + 32'd1) >= 32'(BOOT_WAIT) && !lcd_busy) state <= ST_SPLASH;
        ST_SPLASH: begin
          show_splash_req <= 1'b1;
          state           <= ST_UPDATE_LCD;
        end
        ST_IDLE: begin
          if (power_rel) begin
            state <= ST_SHUTDOWN;
          end else if (send_rel) begin
            instr <= switches;
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: state <= ST_LATCH;
        ST_LATCH: begin
          lcd_opcode    <= op;
          lcd_reg_index <= rd;
          case (op)
            OP_DISPLAY: lcd_value <= rdata_b;
            OP_CLEAR:   lcd_value <= '0;
            default:    lcd_value <= result;
          endcase
          if (op == OP_CLEAR)        overflow_flag <= 1'b0;
          else if (op != OP_DISPLAY) overflow_flag <= ovf;
          state <= ST_UPDATE_LCD;
        end
        ST_UPDATE_LCD: begin
          cnt   <= '0;
          state <= ST_WAIT_LCD;
        end
        ST_WAIT_LCD: begin
          if ((cnt + 32'd1) >= 32'(LCD_MIN_WAIT) && !lcd_busy) begin
            show_splash_req <= 1'b0;
            force_blank_req <= 1'b0;
            if (force_blank_req) begin
              system_reset_out <= 1'b1;
              state            <= ST_OFF;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_SHUTDOWN: begin
          force_blank_req <= 1'b1;
          state           <= ST_UPDATE_LCD;
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_cpu_core.sv
// tb/tb_mini_cpu_core.sv - directed vector bench running wrap and saturate cores side by side
module tb_mini_cpu_core;

  localparam int BOOT_W = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        button_power = 1'b0;
  logic        button_send = 1'b0;
  logic [17:0] switches = '0;
  logic        lcd_busy = 1'b0;

  logic        sysrst0, splash0, blank0, start0, ready0, ovf0;
  logic        sysrst1, splash1, blank1, start1, ready1, ovf1;
  logic [2:0]  opc0, opc1;
  logic [3:0]  idx0, idx1;
  logic [15:0] val0, val1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mini_cpu_core #(.SAT_MODE(0), .BOOT_WAIT(BOOT_W), .LCD_MIN_WAIT(15)) u_dut_wrap (
    .clk(clk), .rst(rst), .button_power(button_power), .button_send(button_send),
    .switches(switches), .system_reset_out(sysrst0), .show_splash_req(splash0),
    .force_blank_req(blank0), .lcd_start(start0), .lcd_opcode(opc0),
    .lcd_reg_index(idx0), .lcd_value(val0), .lcd_busy(lcd_busy),
    .cpu_ready(ready0), .overflow_flag(ovf0)
  );

  mini_cpu_core #(.SAT_MODE(1), .BOOT_WAIT(BOOT_W), .LCD_MIN_WAIT(15)) u_dut_sat (
    .clk(clk), .rst(rst), .button_power(button_power), .button_send(button_send),
    .switches(switches), .system_reset_out(sysrst1), .show_splash_req(splash1),
    .force_blank_req(blank1), .lcd_start(start1), .lcd_opcode(opc1),
    .lcd_reg_index(idx1), .lcd_value(val1), .lcd_busy(lcd_busy),
    .cpu_ready(ready1), .overflow_flag(ovf1)
  );

  typedef struct {
    logic [17:0] sw;
    logic        chg;
    logic [17:0] chg_sw;
    logic [15:0] v0;
    logic        o0;
    logic [15:0] v1;
    logic        o1;
  } vec_t;

  function automatic logic [17:0] mk(input logic [2:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [6:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic vec_t mkv(input logic [17:0] sw, input logic [15:0] v0, input logic o0,
                               input logic [15:0] v1, input logic o1);
    vec_t v;
    v.sw = sw; v.chg = 1'b0; v.chg_sw = sw;
    v.v0 = v0; v.o0 = o0; v.v1 = v1; v.o1 = o1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic power_pulse();
    @(posedge clk); #1 button_power = 1'b1;
    @(posedge clk); #1 button_power = 1'b0;
  endtask

  task automatic send_pulse(input logic [17:0] w);
    @(posedge clk); #1 switches = w; button_send = 1'b1;
    @(posedge clk); #1 button_send = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready0) begin ok = 1'b1; break; end
    end
    chk({tag, "_ready"}, 32'(ok), 32'd1);
  endtask

  task automatic run_instr(input vec_t v, input string tag);
    int start_k;
    int pulses;
    start_k = -1;
    pulses = 0;
    send_pulse(v.sw);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (start0) begin
        pulses++;
        if (start_k < 0) start_k = k;
      end
      if (k == 1 && v.chg) switches = v.chg_sw;
      if (k == 3) begin
        chk({tag, "_val_wrap"}, 32'(val0), 32'(v.v0));
        chk({tag, "_ovf_wrap"}, 32'(ovf0), 32'(v.o0));
        chk({tag, "_val_sat"},  32'(val1), 32'(v.v1));
        chk({tag, "_ovf_sat"},  32'(ovf1), 32'(v.o1));
        chk({tag, "_idx"},      32'(idx0), 32'(v.sw[14:11]));
        chk({tag, "_opc"},      32'(opc0), 32'(v.sw[17:15]));
      end
    end
    chk({tag, "_start_cycle"}, 32'(start_k), 32'd4);
    chk({tag, "_start_once"},  32'(pulses), 32'd1);
    wait_ready(tag);
  endtask

  task automatic boot(input string tag);
    int n;
    int pulses;
    bit found, splash_ok, ok;
    n = 0; pulses = 0; found = 0; splash_ok = 0; ok = 0;
    power_pulse();
    for (int i = 0; i < BOOT_W + 300; i++) begin
      @(negedge clk);
      if (!found) n++;
      if (start0) begin
        pulses++;
        if (!found) begin found = 1'b1; splash_ok = splash0 & splash1; end
      end
      if (ready0) begin ok = 1'b1; break; end
    end
    chk({tag, "_ready"}, 32'(ok), 32'd1);
    chk({tag, "_sysrst_low"}, 32'(sysrst0), 32'd0);
    chk({tag, "_latency"}, 32'(n >= BOOT_W && n <= BOOT_W + 10), 32'd1);
    chk({tag, "_start_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_splash_at_start"}, 32'(splash_ok), 32'd1);
    chk({tag, "_splash_cleared"}, 32'(splash0), 32'd0);
  endtask

  vec_t vecs[18];

  initial begin
    vec_t v;
    int pulses;
    bit blank_ok, off_ok, ready_seen;

    vecs[0]  = mkv(mk(3'd0, 4'd3, 4'd0, 7'h45), 16'hFFFB, 0, 16'hFFFB, 0);
    vecs[1]  = mkv(mk(3'd7, 4'd3, 4'd0, 7'h00), 16'hFFFB, 0, 16'hFFFB, 0);
    vecs[2]  = mkv(mk(3'd0, 4'd1, 4'd0, 7'h3F), 16'h003F, 0, 16'h003F, 0);
    vecs[3]  = mkv(mk(3'd5, 4'd1, 4'd1, 7'h3F), 16'h0F81, 0, 16'h0F81, 0);
    vecs[4]  = mkv(mk(3'd5, 4'd1, 4'd1, 7'h3F), 16'hD0BF, 1, 16'h7FFF, 1);
    vecs[5]  = mkv(mk(3'd5, 4'd1, 4'd1, 7'h3F), 16'h5F01, 1, 16'h7FFF, 1);
    vecs[6]  = mkv(mk(3'd5, 4'd1, 4'd1, 7'h3F), 16'h613F, 1, 16'h7FFF, 1);
    vecs[7]  = mkv(mk(3'd0, 4'd4, 4'd0, 7'h0A), 16'h000A, 0, 16'h000A, 0);
    vecs[8]  = mkv(mk(3'd1, 4'd5, 4'd4, 7'h08), 16'h6149, 0, 16'h7FFF, 1);
    vecs[9]  = mkv(mk(3'd3, 4'd6, 4'd4, 7'h18), 16'h000F, 0, 16'h000F, 0);
    vecs[10] = mkv(mk(3'd2, 4'd7, 4'd3, 7'h40), 16'hFFFB, 0, 16'hFFFB, 0);
    vecs[11] = mkv(mk(3'd4, 4'd8, 4'd4, 7'h7F), 16'h0049, 0, 16'h0049, 0);
    vecs[12] = mkv(mk(3'd0, 4'd9, 4'd0, 7'h7F), 16'hFFC1, 0, 16'hFFC1, 0);
    vecs[13] = mkv(mk(3'd5, 4'd9, 4'd9, 7'h3F), 16'hF07F, 0, 16'hF07F, 0);
    vecs[14] = mkv(mk(3'd5, 4'd9, 4'd9, 7'h3F), 16'h2F41, 1, 16'h8000, 1);
    vecs[15] = mkv(mk(3'd7, 4'd9, 4'd0, 7'h00), 16'h2F41, 1, 16'h8000, 1);
    vecs[16] = mkv(mk(3'd6, 4'd0, 4'd0, 7'h00), 16'h0000, 0, 16'h0000, 0);
    vecs[17] = mkv(mk(3'd7, 4'd3, 4'd0, 7'h00), 16'h0000, 0, 16'h0000, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sysrst", 32'(sysrst0 & sysrst1), 32'd1);
    chk("rst_ready", 32'(ready0 | ready1), 32'd0);
    chk("rst_start", 32'(start0 | start1), 32'd0);
    chk("rst_reqs", 32'({splash0, blank0, splash1, blank1}), 32'd0);
    chk("rst_ovf", 32'(ovf0 | ovf1), 32'd0);
    chk("rst_lcd", 32'({opc0, idx0, val0}), 32'd0);
    #1 rst = 1'b0;

    boot("boot1");

    for (int i = 0; i < 18; i++) run_instr(vecs[i], $sformatf("vec%0d", i));

    // Switch word changed one cycle after the snapshot must not leak in.
    v = mkv(mk(3'd0, 4'd10, 4'd0, 7'h11), 16'h0011, 0, 16'h0011, 0);
    v.chg = 1'b1;
    v.chg_sw = mk(3'd0, 4'd10, 4'd0, 7'h22);
    run_instr(v, "snap");
    run_instr(mkv(mk(3'd7, 4'd10, 4'd0, 7'h00), 16'h0011, 0, 16'h0011, 0), "snap_disp");

    // LCD stays busy: FSM parks in WAIT_LCD and ignores a send release.
    lcd_busy = 1'b1;
    send_pulse(mk(3'd0, 4'd11, 4'd0, 7'h05));
    repeat (10) @(negedge clk);
    chk("busy_early", 32'(ready0), 32'd0);
    send_pulse(mk(3'd0, 4'd12, 4'd0, 7'h07));
    repeat (30) @(negedge clk);
    chk("busy_hold", 32'(ready0), 32'd0);
    chk("busy_val", 32'(val0), 32'h0005);
    lcd_busy = 1'b0;
    wait_ready("busy_release");
    ready_seen = 1'b1;
    repeat (5) begin
      @(negedge clk);
      ready_seen = ready_seen & ready0;
    end
    chk("busy_no_queue", 32'(ready_seen), 32'd1);
    run_instr(mkv(mk(3'd7, 4'd12, 4'd0, 7'h00), 16'h0000, 0, 16'h0000, 0), "busy_r12");
    run_instr(mkv(mk(3'd7, 4'd11, 4'd0, 7'h00), 16'h0005, 0, 16'h0005, 0), "busy_r11");

    // Power release in IDLE: blank request with one LCD pulse, then OFF.
    pulses = 0; blank_ok = 0; off_ok = 0;
    power_pulse();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (start0) begin pulses++; blank_ok = blank0 & blank1; end
      if (sysrst0) begin off_ok = 1'b1; break; end
    end
    chk("shut_off", 32'(off_ok), 32'd1);
    chk("shut_pulses", 32'(pulses), 32'd1);
    chk("shut_blank", 32'(blank_ok), 32'd1);
    chk("shut_ready", 32'(ready0), 32'd0);
    repeat (3) @(negedge clk);
    chk("shut_stays_off", 32'({sysrst0, ready0, blank0}), 32'b100);

    boot("boot2");
    run_instr(mkv(mk(3'd7, 4'd11, 4'd0, 7'h00), 16'h0000, 0, 16'h0000, 0), "reboot_r11");
    run_instr(mkv(mk(3'd7, 4'd10, 4'd0, 7'h00), 16'h0000, 0, 16'h0000, 0), "reboot_r10");

    // rst while in EXECUTE: OFF on the next cycle and the write never lands.
    send_pulse(mk(3'd0, 4'd13, 4'd0, 7'h09));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_in_exec", 32'(ready0), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_off", 32'({sysrst0, ready0, start0}), 32'b100);
    chk("abort_lcd", 32'(val0), 32'd0);
    boot("boot3");
    run_instr(mkv(mk(3'd7, 4'd13, 4'd0, 7'h00), 16'h0000, 0, 16'h0000, 0), "abort_r13");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/mini_cpu_core.md
Name: mini_cpu_core

Overview:
- Parametrised successor of the switch-driven mini CPU controller.
- Takes one instruction word from board switches on each release of the send button and executes it against an internal register file.
- Drives the LCD command interface, global reset, splash and blank requests.
- Adds over the previous generation: generic data width and register count, an instruction snapshot, selectable wrap/saturate arithmetic, an overflow flag and a ready status.

Parameters:
- DATA_W, 16: register and LCD value width (≥8).
- NUM_REGS, 16: register count, power of two; RA_W = clog2(NUM_REGS).
- IMM_W, 7: sign-magnitude immediate width (1 sign bit + IMM_W-1 magnitude); IMM_W ≥ RA_W.
- SAT_MODE, 0: 0 = wrap arithmetic, 1 = saturate to signed min/max.
- BOOT_WAIT, 1000: cycles waited after power-on before polling lcd_busy.
- LCD_MIN_WAIT, 15: minimum cycles in WAIT_LCD before lcd_busy is sampled.

Ports:
- clk  in  1  system clock; the block has one clock.
- rst  in  1  synchronous, active-high reset.
- button_power  in  1  power button, 1 = pressed.
- button_send  in  1  execute button, 1 = pressed.
- switches  in  3+2*RA_W+IMM_W  instruction word (field layout under Behaviour).
- system_reset_out  out  1  global reset to the rest of the system.
- show_splash_req  out  1  LCD splash request.
- force_blank_req  out  1  LCD blank request.
- lcd_start  out  1  one-cycle LCD command pulse.
- lcd_opcode  out  3  opcode shown on the LCD.
- lcd_reg_index  out  RA_W  register index shown on the LCD.
- lcd_value  out  DATA_W  value shown on the LCD.
- lcd_busy  in  1  LCD controller busy.
- cpu_ready  out  1  high only in IDLE.
- overflow_flag  out  1  overflow status of the last writing instruction.

Behaviour:
- Instruction field layout, MSB first:
  - op: 3 bits.
  - rd: RA_W bits.
  - rs1: RA_W bits.
  - imm: IMM_W bits.
  - rs2 = the top RA_W bits of imm.
- Immediate decode: sign-magnitude. Magnitude is zero-extended to DATA_W and negated when the sign bit is 1; −0 decodes to 0.
- Opcodes:
  - LOAD=0: rd = imm.
  - ADD=1: rd = rs1 + rs2.
  - ADDI=2: rd = rs1 + imm.
  - SUB=3: rd = rs1 − rs2.
  - SUBI=4: rd = rs1 − imm.
  - MUL=5: rd = rs1 × imm.
  - CLEAR=6: all registers = 0.
  - DISPLAY=7: reads rd, writes nothing.
- Arithmetic is signed. The exact result is computed at 2*DATA_W and then:
  - SAT_MODE=0: truncated to DATA_W.
  - SAT_MODE=1: clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - In either mode overflow_flag is set if the exact result lies outside that range.
- overflow_flag update rules: updated by every writing op; cleared by CLEAR and by rst; unchanged by DISPLAY.
- Button edges: registered 1→0 transitions only; edge registers reset to 0 on rst.
- Reset values:
  - state = OFF.
  - system_reset_out = 1.
  - lcd_start, show_splash_req, force_blank_req, cpu_ready, overflow_flag = 0.
  - lcd_opcode, lcd_reg_index, lcd_value = 0.
  - All registers = 0.
  - rst mid-operation aborts immediately to OFF; no register write completes.
- State machine:
  - OFF: system_reset_out=1 and registers held cleared. On power release: system_reset_out=0, go to WAIT_BOOT.
  - WAIT_BOOT: count to BOOT_WAIT, then advance to SPLASH once lcd_busy=0.
  - SPLASH: show_splash_req=1, go to UPDATE_LCD.
  - IDLE: cpu_ready=1, all requests 0. On power release go to SHUTDOWN; otherwise on send release, snapshot switches into an instruction register and go to EXECUTE. If both releases occur in the same cycle, power wins.
  - EXECUTE: operands are read from the snapshot only; switch changes after the snapshot have no effect.
  - LATCH: register write at the end of this cycle; lcd_opcode=op, lcd_reg_index=rd, lcd_value=result (for DISPLAY the rd value; for CLEAR 0).
  - UPDATE_LCD: go to WAIT_LCD.
  - WAIT_LCD: ≥LCD_MIN_WAIT cycles, then wait for lcd_busy=0. Go to OFF if force_blank_req is set, else to IDLE; splash and blank requests clear on exit.
  - SHUTDOWN: force_blank_req=1, go to UPDATE_LCD.
- Timing: send release sampled in IDLE at cycle T gives EXECUTE at T+1, LATCH at T+2, lcd_* valid from T+3, lcd_start high in T+4 only.
- Button releases outside OFF/IDLE are ignored, not queued.
- Write to rd while rs1 == rd: old value is used.

Decomposition:
- Shared package mini_cpu_pkg holds:
  - Opcode constants.
  - FSM state encoding.
  - Field-slice helper functions for op, rd, rs1, rs2 and imm.
  - The sign-magnitude decode function.
- Sub-module mini_cpu_regfile:
  - NUM_REGS×DATA_W.
  - Two combinational read ports.
  - One write port.
  - Synchronous clear-all (driven by rst or a CLEAR instruction).

Test Plan:
- Boot: rst, then power pulse; lcd_busy=0 → lcd_start pulses once after BOOT_WAIT with show_splash_req=1, then cpu_ready=1.
- LOAD r3, imm=0x45 (−5) then DISPLAY r3 → lcd_value=0xFFFB, lcd_reg_index=3, lcd_start at T+4.
- SAT_MODE=0: LOAD r1=63, MUL r1 by 63 four times → wraps, overflow_flag=1. SAT_MODE=1: same sequence → r1=0x7FFF, overflow_flag=1.
- Send with switches changed at T+1 → result uses the T-sampled switch word.
- lcd_busy held high for 40 cycles → FSM stays in WAIT_LCD and a send release in that time is ignored; IDLE is reached after busy falls.
- Power release in IDLE → force_blank_req=1 with one lcd_start, then OFF with system_reset_out=1. Power again → all registers read 0. rst asserted in EXECUTE → OFF next cycle and no write.
